// File: rtl/e203_itcm_sram_ctrl_if.sv
// ICB-style command/response bundle between the ITCM arbiter and the SRAM
// controller.
//   cmd_*  : request channel. valid/ready handshake; read flag, byte address,
//            write data and byte mask.
//   rsp_*  : response channel. valid/ready handshake; read data and error flag.
// master = arbiter side (drives cmd, consumes rsp); slave = controller side.
interface e203_itcm_sram_ctrl_if #(
  parameter int DW = 64,
  parameter int MW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [31:0]   cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/e203_itcm_sram_ctrl.sv
// ITCM SRAM controller: turns ICB commands into raw SRAM cycles (1-cycle
// read latency), returns responses through a one-entry hold buffer so that
// response back-pressure never drops RAM output, flags out-of-range
// addresses, and puts the RAM into light sleep after LS_IDLE idle cycles.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   icb            : command/response handshake (slave side)
//   ram_cs/we/addr/wem/din : RAM request, combinational from the accepted cmd
//   ram_dout       : RAM read data, valid the cycle after a read cs
//   ram_sd/ds      : shutdown / deep sleep, tied off
//   ram_ls         : light sleep
module e203_itcm_sram_ctrl #(
  parameter int DW      = 64,
  parameter int MW      = 8,
  parameter int AW      = 13,
  parameter int OFS     = 3,
  parameter int LS_IDLE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  e203_itcm_sram_ctrl_if.slave   icb,
  output logic                   ram_cs,
  output logic                   ram_we,
  output logic [AW-1:0]          ram_addr,
  output logic [MW-1:0]          ram_wem,
  output logic [DW-1:0]          ram_din,
  input  logic [DW-1:0]          ram_dout,
  output logic                   ram_sd,
  output logic                   ram_ds,
  output logic                   ram_ls
);
  localparam logic [7:0] LS_MAX = 8'(LS_IDLE);

  logic          err_c, issue, idle;
  logic          pend, p_read, p_err;
  logic          hld_vld, hld_err;
  logic [DW-1:0] hld_data, rsp_data;
  logic          ls;
  logic [7:0]    idle_cnt, idle_cnt_nxt;
  logic          unused_ofs;

  // Byte offset within a word is don't-care; the mask selects bytes.
  assign unused_ofs = ^icb.cmd_addr[OFS-1:0];

  assign err_c         = |icb.cmd_addr[31:AW+OFS];
  // Hold buffer full or a stalled pending response blocks new commands, so
  // pend and hold can never both be occupied.
  assign icb.cmd_ready = !ls && !hld_vld && (!pend || icb.rsp_ready);
  assign issue         = icb.cmd_valid && icb.cmd_ready;

  assign ram_cs   = issue && !err_c;
  assign ram_we   = ram_cs && !icb.cmd_read;
  assign ram_addr = icb.cmd_addr[AW+OFS-1:OFS];
  assign ram_wem  = icb.cmd_wmask;
  assign ram_din  = icb.cmd_wdata;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;
  assign ram_ls   = ls;

  always_comb begin
    rsp_data = '0;
    if (hld_vld)                     rsp_data = hld_data;
    else if (pend && p_read && !p_err) rsp_data = ram_dout;
  end

  assign icb.rsp_valid = pend || hld_vld;
  assign icb.rsp_rdata = rsp_data;
  assign icb.rsp_err   = hld_vld ? hld_err : (pend && p_err);

  // pend lives exactly one cycle: it is either consumed or moved to hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= 1'b0;
      p_read <= 1'b0;
      p_err  <= 1'b0;
    end else begin
      pend <= issue;
      if (issue) begin
        p_read <= icb.cmd_read;
        p_err  <= err_c;
      end
    end
  end

  // RAM output is only valid for one cycle, so a stalled response is
  // captured here before ram_dout moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hld_vld  <= 1'b0;
      hld_err  <= 1'b0;
      hld_data <= '0;
    end else if (pend && !icb.rsp_ready) begin
      hld_vld  <= 1'b1;
      hld_data <= rsp_data;
      hld_err  <= p_err;
    end else if (hld_vld && icb.rsp_ready) begin
      hld_vld  <= 1'b0;
    end
  end

  // Light sleep: set on the edge where the idle count reaches LS_IDLE, held
  // until a command shows up; the wake cycle itself cannot accept.
  assign idle         = !icb.cmd_valid && !pend && !hld_vld;
  assign idle_cnt_nxt = !idle                ? 8'd0     :
                        (idle_cnt == LS_MAX) ? idle_cnt : idle_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= 8'd0;
      ls       <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
      ls       <= ls ? !icb.cmd_valid : (idle_cnt_nxt == LS_MAX);
    end
  end
endmodule
